// File: rtl/alu_pkg.sv
// Shared types for the ALU share arbiter: opcodes, flag layout, FSM states
// and the op-dependent settle-length helper.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        MUL = 3'b010,
        DIV = 3'b011,
        OR  = 3'b100,
        AND = 3'b101,
        SLL = 3'b110,
        SRL = 3'b111
    } alu_op_e;

    localparam int FLG_ZERO = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF = 2;
    localparam int FLG_NEG = 3;
    localparam int FLG_EQ = 4;
    localparam int FLG_BLT = 5;
    localparam int FLG_COUT = 6;
    localparam int FLAGS_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Number of cycles the ALU needs before its outputs may be sampled.
    function automatic int unsigned settle_len(input logic [2:0] op,
                                               input int unsigned mul_c,
                                               input int unsigned div_c);
        if (op == MUL) return mul_c;
        if (op == DIV) return div_c;
        return 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping around, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        any       = |req;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external scalar ALU among NREQ requesters.
// Optional macro ALU_ARB_DIVZ_EN short-circuits divide-by-zero requests.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][2:0]     req_op,
    input  logic [NREQ-1:0][W-1:0]   req_a,
    input  logic [NREQ-1:0][W-1:0]   req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic [2:0]               alu_op,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic                     alu_cin,
    input  logic [W-1:0]             alu_result,
    input  logic [FLAGS_W-1:0]       alu_flags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [W-1:0]             rsp_result,
    output logic [FLAGS_W-1:0]       rsp_flags,
    output logic                     rsp_divz
);

    localparam int LMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(LMAX + 1);

    arb_state_e state, nstate;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            any;
    logic            hs;
    logic [2:0]      sel_op;
    logic [W-1:0]    sel_a, sel_b;
    logic            sel_cin;
    logic            sel_divz;
    logic [CW-1:0]   load;
    logic [W-1:0]    cap_result;
    logic [FLAGS_W-1:0] cap_flags;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign sel_op  = req_op[grant_idx];
    assign sel_a   = req_a[grant_idx];
    assign sel_b   = req_b[grant_idx];
    assign sel_cin = req_cin[grant_idx];
    assign hs      = |req_ready;
    assign load    = sel_divz ? '0 : CW'(settle_len(sel_op, MUL_CYCLES, DIV_CYCLES) - 1);

`ifdef ALU_ARB_DIVZ_EN
    logic divz_pend;

    assign sel_divz   = (sel_op == DIV) && (sel_b == '0);
    assign cap_result = divz_pend ? '1 : alu_result;
    assign cap_flags  = divz_pend ? '0 : alu_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            divz_pend <= 1'b0;
            rsp_divz  <= 1'b0;
        end else if (state == IDLE && hs) begin
            divz_pend <= sel_divz;
        end else if (state == EXEC && cnt == '0) begin
            rsp_divz  <= divz_pend;
        end
    end
`else
    assign sel_divz   = 1'b0;
    assign cap_result = alu_result;
    assign cap_flags  = alu_flags;
    assign rsp_divz   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (hs) nstate = EXEC;
            EXEC:    if (cnt == '0) nstate = RESP;
            RESP:    if (rsp_valid && rsp_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Grant is only offered while idle; hs depends on it so it stays reset-gated.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && any) req_ready = grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            cnt        <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    alu_op  <= sel_divz ? 3'(ADD) : sel_op;
                    alu_a   <= sel_divz ? '0 : sel_a;
                    alu_b   <= sel_divz ? '0 : sel_b;
                    alu_cin <= sel_divz ? 1'b0 : sel_cin;
                    rsp_id  <= grant_idx;
                    ptr     <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                    cnt     <= load;
                end
                EXEC: if (cnt == '0) begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= cap_result;
                    rsp_flags  <= cap_flags;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one scalar ALU (escal_ALU) between NREQ requesters, e.g. scalar core and vector/DMA address unit.
- Uses round-robin arbitration and valid/ready handshakes on each side.
- Registers operands toward the ALU and waits an op-dependent settle time for MUL/DIV.
- Captures result and flags into a response register tagged with the requester ID.

Parameters:
- NREQ, 2, number of requesters (2..8)
- W, 32, operand/result width
- MUL_CYCLES, 2, settle cycles for op 010 (>=1)
- DIV_CYCLES, 4, settle cycles for op 011 (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  one-hot accept
- req_op  in  NREQ x 3  ALU opcode
- req_a  in  NREQ x W  operand A
- req_b  in  NREQ x W  operand B
- req_cin  in  NREQ  carry in
- alu_op  out  3  to ALU
- alu_a  out  W  to ALU
- alu_b  out  W  to ALU
- alu_cin  out  1  to ALU
- alu_result  in  W  from ALU
- alu_flags  in  7  from ALU: [0]Zero [1]Carry [2]OverFlow [3]Negative [4]eq [5]blt [6]Cout
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  clog2(NREQ)  granted requester index
- rsp_result  out  W  captured result
- rsp_flags  out  7  captured flags, same layout as alu_flags
- rsp_divz  out  1  divide-by-zero marker (see Optional Feature)

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, rr pointer=0, cycle counter=0. All registered outputs are 0: rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_divz, alu_op, alu_a, alu_b, alu_cin. req_ready=0 while rst high.
- Reset mid-operation (EXEC or RESP) discards the in-flight op; no response is issued.
- FSM states:
  - IDLE: if any req_valid, grant the first valid index scanning from the rr pointer upward, with wrap. req_ready[grant]=1 combinationally; all other bits 0. At the handshake edge, latch op/a/b/cin into the alu_* registers and the grant into rsp_id. Set pointer=(grant+1) mod NREQ. Load counter with L-1 and go to EXEC.
  - Settle length L: L=MUL_CYCLES for 010, DIV_CYCLES for 011, 1 otherwise.
  - EXEC: counter decrements each cycle. When counter==0, capture alu_result/alu_flags into rsp_result/rsp_flags, set rsp_valid=1, go to RESP.
  - RESP: hold all rsp_* stable until rsp_valid&&rsp_ready. At that edge clear rsp_valid and go to IDLE. The alu_* registers keep their last values.
- req_ready is 0 in EXEC and RESP. No new grant occurs in the same cycle as the response handshake.
- Latency: handshake at edge N; rsp_valid high from cycle N+1+L. Minimum issue interval is L+2 cycles.
- Requesters hold valid and payload stable until ready; valid must not depend on ready.
- Pointer advances only on grant. A lone requester is granted repeatedly; the pointer skips invalid indices.
- The arbiter does no arithmetic; the ALU is external. Flag widths pass through unchanged.

Optional Feature:
- Macro ALU_ARB_DIVZ_EN.
- Defined: at grant, op==011 with b==0 sets L=1 and drives alu_op=000 with a=b=0. The response returns rsp_result = all ones, rsp_flags=0, rsp_divz=1.
- Undefined: divide-by-zero goes to the ALU normally and rsp_divz is tied to 0.

Decomposition:
- Package alu_pkg:
  - alu_op_e: ADD=000 SUB=001 MUL=010 DIV=011 OR=100 AND=101 SLL=110 SRL=111
  - Flag index localparams FLG_ZERO..FLG_COUT, and FLAGS_W=7
  - Arbiter state enum arb_state_e {IDLE, EXEC, RESP}
- Sub-module rr_arbiter: parameter NREQ; inputs req, ptr; outputs one-hot grant, grant_idx, any. Purely combinational.

Test Plan:
- Req0 ADD a=6 b=2 cin=0, ALU model returns 8 -> req_ready[0] at accept; rsp_valid 2 cycles later with rsp_id=0, result=8, Zero=0.
- Req1 DIV a=300 b=30 with DIV_CYCLES=4 -> rsp_valid exactly 5 cycles after handshake, result=10, id=1. Req0 asserted meanwhile sees req_ready[0]=0 throughout.
- Both requesters valid continuously with SUB (10-5 on req0, 5-10 on req1) -> grants alternate 0,1,0,1. Results 5 and 0xFFFFFFFB with Negative=1 on req1.
- rsp_ready held low 3 cycles after a MUL 10*30 -> rsp_result=300 and rsp_id held stable; no new grant until the response handshake.
- rst asserted in cycle 2 of a DIV EXEC -> next cycle all outputs 0, rsp_valid never rises; a subsequent req1 OR 10|1 returns 11.
- With ALU_ARB_DIVZ_EN, DIV a=7 b=0 -> rsp_result=0xFFFFFFFF, rsp_divz=1, latency 2. Without the macro -> latency 1+DIV_CYCLES and rsp_divz=0.
